// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: bring-up and health controller for one SB_PLL40_CORE.
// Holds the PLL in reset, waits for a synchronised and debounced LOCK,
// raises clk_ready, and retries on timeout or lock loss until the retry
// budget is spent. Runs entirely in the REFERENCECLK domain.
// Build option: define PLL_BYPASS_FALLBACK_EN to let FAULT release the PLL
// from reset with BYPASS=1 so the reference clock is passed through.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | enable low; PLL held in reset
// RST_HOLD  | PLL RESETB held low for RESET_CYCLES cycles
// WAIT_LOCK | RESETB released, waiting for lock_s (bounded by LOCK_TIMEOUT)
// STABLE    | lock_s high, counting towards LOCK_STABLE consecutive cycles
// RUNNING   | clk_ready asserted; lock loss is a failure
// FAULT     | retry budget exhausted; waits for relock_req or enable low

module pll_lock_sequencer #(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 256,
    parameter int MAX_RETRIES  = 3,
    localparam int RW          = $clog2(MAX_RETRIES + 2)
) (
    input  logic          REFERENCECLK,
    input  logic          RESET,
    input  logic          enable,
    input  logic          relock_req,
    input  logic          pll_lock,
    output logic          pll_resetb,
    output logic          pll_bypass,
    output logic          clk_ready,
    output logic          fault,
    output logic [RW-1:0] retry_count,
    output logic [2:0]    state_dbg
);

    localparam int CNT_MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE) ? CNT_MAX_A : LOCK_STABLE;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

`ifdef PLL_BYPASS_FALLBACK_EN
    localparam logic FALLBACK = 1'b1;
`else
    localparam logic FALLBACK = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RST_HOLD  = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_STABLE    = 3'd3,
        S_RUNNING   = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [RW-1:0]    r_retry;
    logic             r_resetb;
    logic             r_bypass;
    logic             r_ready;
    logic             r_fault;
    logic             r_lock_meta;
    logic             r_lock_s;
    logic             w_relock;
    logic             w_fail;

    // relock_req only matters once the PLL has been up or has given up
    assign w_relock = relock_req && (r_state == S_RUNNING || r_state == S_FAULT);

    // A timeout only fails if lock_s is still low on the last cycle; lock wins ties
    assign w_fail = ((r_state == S_WAIT_LOCK) && !r_lock_s &&
                     (r_cnt == CNT_W'(LOCK_TIMEOUT - 1))) ||
                    ((r_state == S_RUNNING) && !r_lock_s);

    // Two-flop synchroniser for the asynchronous LOCK pin
    always_ff @(posedge REFERENCECLK) begin
        if (!RESET) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_s    <= r_lock_meta;
        end
    end

    // Sequencer FSM with registered PLL controls and status
    always_ff @(posedge REFERENCECLK) begin
        if (!RESET) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_retry  <= '0;
            r_resetb <= 1'b0;
            r_bypass <= 1'b0;
            r_ready  <= 1'b0;
            r_fault  <= 1'b0;
        end else if (!enable) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_resetb <= 1'b0;
            r_bypass <= 1'b0;
            r_ready  <= 1'b0;
            r_fault  <= 1'b0;
        end else if (w_relock) begin
            r_state  <= S_RST_HOLD;
            r_cnt    <= '0;
            r_retry  <= '0;
            r_resetb <= 1'b0;
            r_bypass <= 1'b0;
            r_ready  <= 1'b0;
            r_fault  <= 1'b0;
        end else if (w_fail) begin
            r_cnt   <= '0;
            r_ready <= 1'b0;
            if (r_retry < RW'(MAX_RETRIES)) begin
                r_retry  <= r_retry + 1'b1;
                r_state  <= S_RST_HOLD;
                r_resetb <= 1'b0;
            end else begin
                r_retry  <= RW'(MAX_RETRIES + 1);
                r_state  <= S_FAULT;
                r_fault  <= 1'b1;
                r_resetb <= FALLBACK;
                r_bypass <= FALLBACK;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state  <= S_RST_HOLD;
                    r_cnt    <= '0;
                    r_resetb <= 1'b0;
                end
                S_RST_HOLD: begin
                    if (r_cnt == CNT_W'(RESET_CYCLES - 1)) begin
                        r_state  <= S_WAIT_LOCK;
                        r_cnt    <= '0;
                        r_resetb <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        // the cycle that saw lock_s counts as the first stable cycle
                        if (LOCK_STABLE == 1) begin
                            r_state <= S_RUNNING;
                            r_cnt   <= '0;
                            r_ready <= 1'b1;
                            r_retry <= '0;
                        end else begin
                            r_state <= S_STABLE;
                            r_cnt   <= CNT_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!r_lock_s) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_W'(LOCK_STABLE - 1)) begin
                        r_state <= S_RUNNING;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_retry <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RUNNING: begin
                    r_ready <= 1'b1;
                end
                S_FAULT: begin
                    r_fault <= 1'b1;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_cnt    <= '0;
                    r_resetb <= 1'b0;
                    r_bypass <= 1'b0;
                    r_ready  <= 1'b0;
                    r_fault  <= 1'b0;
                end
            endcase
        end
    end

    assign pll_resetb  = r_resetb;
    assign pll_bypass  = r_bypass;
    assign clk_ready   = r_ready;
    assign fault       = r_fault;
    assign retry_count = r_retry;
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with RESET_CYCLES=4, LOCK_TIMEOUT=32,
// LOCK_STABLE=8, MAX_RETRIES=2.

module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       relock_req;
    logic       pll_lock;
    logic       pll_resetb;
    logic       pll_bypass;
    logic       clk_ready;
    logic       fault;
    logic [1:0] retry_count;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    pll_lock_sequencer #(
        .RESET_CYCLES(4),
        .LOCK_TIMEOUT(32),
        .LOCK_STABLE (8),
        .MAX_RETRIES (2)
    ) dut (
        .REFERENCECLK(clk),
        .RESET       (rst_n),
        .enable      (enable),
        .relock_req  (relock_req),
        .pll_lock    (pll_lock),
        .pll_resetb  (pll_resetb),
        .pll_bypass  (pll_bypass),
        .clk_ready   (clk_ready),
        .fault       (fault),
        .retry_count (retry_count),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       relock;
        logic       lock;
        logic       resetb;
        logic       ready;
        logic       fault;
        logic [1:0] retry;
        logic [2:0] state;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] exp, input int bound, input string name);
        for (int k = 0; k < bound && state_dbg !== exp; k++) tick();
        check(name, {29'd0, state_dbg}, {29'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic saw_wait;

        // rst_n en relock lock | resetb ready fault retry state
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd2};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd2};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd2};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd3};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0};

        rst_n = 1'b0; enable = 1'b0; relock_req = 1'b0; pll_lock = 1'b0;
        #2;

        for (int i = 0; i < 14; i++) begin
            rst_n      = vecs[i].rst_n;
            enable     = vecs[i].en;
            relock_req = vecs[i].relock;
            pll_lock   = vecs[i].lock;
            tick();
            check($sformatf("vec%0d", i),
                  {24'd0, pll_resetb, clk_ready, fault, retry_count, state_dbg},
                  {24'd0, vecs[i].resetb, vecs[i].ready, vecs[i].fault, vecs[i].retry, vecs[i].state});
        end
        relock_req = 1'b0;

        // nominal bring-up
        rst_n = 1'b0; enable = 1'b0; pll_lock = 1'b0;
        tick(); tick();
        rst_n = 1'b1; enable = 1'b1;
        wait_state(3'd1, 10, "enter_rst_hold");
        n = 0;
        for (int k = 0; k < 20 && state_dbg == 3'd1; k++) begin
            if (pll_resetb !== 1'b0) n = 100;
            n++;
            tick();
        end
        check("rst_hold_len", n, 4);
        check("wait_lock_resetb", {state_dbg, pll_resetb}, {3'd2, 1'b1});
        for (int k = 0; k < 9; k++) tick();
        pll_lock = 1'b1;
        n = 0;
        for (int k = 0; k < 40 && !clk_ready; k++) begin
            tick();
            n++;
        end
        check("ready_latency", n, 10);
        check("running_state", {retry_count, state_dbg}, {2'd0, 3'd4});

        // glitchy lock
        relock_req = 1'b1; pll_lock = 1'b0;
        tick();
        relock_req = 1'b0;
        check("relock_from_running", {clk_ready, fault, retry_count, state_dbg},
              {1'b0, 1'b0, 2'd0, 3'd1});
        wait_state(3'd2, 20, "glitch_wait_lock");
        pll_lock = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        n = 6;
        saw_wait = 1'b0;
        for (int k = 0; k < 40 && !clk_ready; k++) begin
            tick();
            n++;
            if (state_dbg == 3'd2) saw_wait = 1'b1;
        end
        check("glitch_ready_latency", n, 16);
        check("glitch_back_to_wait", saw_wait, 1'b1);
        check("glitch_retry", retry_count, 2'd0);

        // lock loss in RUNNING
        pll_lock = 1'b0;
        n = 0;
        for (int k = 0; k < 10 && clk_ready; k++) begin
            tick();
            n++;
        end
        check("loss_latency", n, 3);
        check("loss_state", {retry_count, state_dbg}, {2'd1, 3'd1});

        // exhaustion from a fresh start
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            n = 0;
            for (int k = 0; k < 80 && retry_count != r; k++) begin
                tick();
                if (state_dbg == 3'd2) n++;
            end
            check($sformatf("timeout_len%0d", r), n, 32);
            check($sformatf("retry%0d", r), retry_count, r);
        end
        check("fault_state", {fault, clk_ready, state_dbg}, {1'b1, 1'b0, 3'd5});
`ifdef PLL_BYPASS_FALLBACK_EN
        check("fault_pll_pins", {pll_bypass, pll_resetb}, {1'b1, 1'b1});
`else
        check("fault_pll_pins", {pll_bypass, pll_resetb}, {1'b0, 1'b0});
`endif
        tick(); tick(); tick();
        check("fault_sticky", {fault, state_dbg}, {1'b1, 3'd5});

        // recovery
        pll_lock = 1'b1; relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        check("recover_edge", {fault, retry_count, state_dbg, pll_bypass, pll_resetb},
              {1'b0, 2'd0, 3'd1, 1'b0, 1'b0});
        n = 0;
        for (int k = 0; k < 20 && state_dbg == 3'd1; k++) begin
            n++;
            tick();
        end
        check("recover_rst_hold_len", n, 4);
        for (int k = 0; k < 30 && !clk_ready; k++) tick();
        check("recover_running", {clk_ready, state_dbg}, {1'b1, 3'd4});

        // reset during STABLE
        relock_req = 1'b1; pll_lock = 1'b0;
        tick();
        relock_req = 1'b0;
        wait_state(3'd2, 20, "reach_wait_lock");
        pll_lock = 1'b1;
        wait_state(3'd3, 10, "reach_stable");
        rst_n = 1'b0;
        tick();
        check("reset_in_stable",
              {pll_resetb, pll_bypass, clk_ready, fault, retry_count, state_dbg}, 9'd0);

        // enable low during WAIT_LOCK
        rst_n = 1'b1; enable = 1'b1; pll_lock = 1'b0;
        wait_state(3'd2, 20, "reach_wait_lock2");
        enable = 1'b0;
        tick();
        check("disable_in_wait", {pll_resetb, state_dbg}, {1'b0, 3'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
